// File: rtl/reg_xfer_ctrl.sv
// Bus sequencer for a bank of bus registers: one word per request, moved
// register-to-register or from an external source, with busy/done/err handshake.
module reg_xfer_ctrl #(
    parameter int NREG  = 4,
    parameter int SEL_W = 2,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             req,
    input  logic [SEL_W-1:0] src,
    input  logic [SEL_W-1:0] dst,
    input  logic             ext,
    input  logic [WIDTH-1:0] ext_data,
    input  logic [WIDTH-1:0] bus_in,
    output logic [NREG-1:0]  oen,
    output logic [NREG-1:0]  inen,
    output logic             bus_oe,
    output logic [WIDTH-1:0] bus_out,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] last_data
);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        LATCH,
        FIN
    } state_t;

    localparam logic [SEL_W:0] NREG_LIM = (SEL_W + 1)'(NREG);

    state_t           r_state;
    logic [SEL_W-1:0] r_dst;

    logic             w_srcOob;
    logic             w_dstOob;
    logic             w_reject;
    logic [NREG-1:0]  w_srcHot;
    logic [NREG-1:0]  w_dstHot;

    // The source index only matters for register-to-register moves.
    assign w_srcOob = ({1'b0, src} >= NREG_LIM);
    assign w_dstOob = ({1'b0, dst} >= NREG_LIM);
    assign w_reject = w_dstOob | (~ext & (w_srcOob | (src == dst)));
    assign w_srcHot = {{(NREG-1){1'b0}}, 1'b1} << src;
    assign w_dstHot = {{(NREG-1){1'b0}}, 1'b1} << r_dst;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state   <= IDLE;
            r_dst     <= '0;
            oen       <= '0;
            inen      <= '0;
            bus_oe    <= '0;
            bus_out   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            last_data <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req) begin
                        r_dst <= dst;
                        busy  <= 1'b1;
                        if (w_reject) begin
                            done    <= 1'b1;
                            err     <= 1'b1;
                            r_state <= FIN;
                        end else begin
                            if (ext) begin
                                bus_oe  <= 1'b1;
                                bus_out <= ext_data;
                            end else begin
                                oen <= w_srcHot;
                            end
                            r_state <= DRIVE;
                        end
                    end
                end
                DRIVE: begin
                    inen    <= w_dstHot;
                    r_state <= LATCH;
                end
                // Destination captures at this edge; mirror the bus word for the requester.
                LATCH: begin
                    oen       <= '0;
                    inen      <= '0;
                    bus_oe    <= 1'b0;
                    done      <= 1'b1;
                    last_data <= bus_in;
                    r_state   <= FIN;
                end
                FIN: begin
                    done    <= 1'b0;
                    err     <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_xfer_ctrl.sv
// Bench for reg_xfer_ctrl: register bank on a shared bus, transaction-level
// expectation queue, directed scenarios and randomized traffic.
module tb_reg_xfer_ctrl;

    localparam int NREG  = 4;
    localparam int SEL_W = 2;
    localparam int WIDTH = 4;

    logic             clk;
    logic             clr;
    logic             req;
    logic [SEL_W-1:0] src;
    logic [SEL_W-1:0] dst;
    logic             ext;
    logic [WIDTH-1:0] ext_data;
    logic [WIDTH-1:0] busIn;
    logic [NREG-1:0]  oen;
    logic [NREG-1:0]  inen;
    logic             bus_oe;
    logic [WIDTH-1:0] bus_out;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] last_data;

    logic [WIDTH-1:0] bank [NREG];

    int checks   = 0;
    int failures = 0;
    int doneSeen = 0;
    int inenSeen = 0;

    typedef struct packed {
        logic [NREG-1:0]  oen;
        logic [NREG-1:0]  inen;
        logic             busOe;
        logic             busy;
        logic             done;
        logic             err;
        logic             setLd;
        logic [WIDTH-1:0] ldVal;
        logic [SEL_W-1:0] dst;
    } exp_t;

    exp_t             q[$];
    exp_t             cur;
    logic             checkEn;
    logic [WIDTH-1:0] expBusOut;
    logic [WIDTH-1:0] expLastData;

    reg_xfer_ctrl #(.NREG(NREG), .SEL_W(SEL_W), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        .clr      (clr),
        .req      (req),
        .src      (src),
        .dst      (dst),
        .ext      (ext),
        .ext_data (ext_data),
        .bus_in   (busIn),
        .oen      (oen),
        .inen     (inen),
        .bus_oe   (bus_oe),
        .bus_out  (bus_out),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .last_data(last_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared bus: whichever driver the controller enables, idle value 0.
    always_comb begin
        busIn = '0;
        if (bus_oe) busIn = bus_out;
        for (int i = 0; i < NREG; i++) begin
            if (oen[i]) busIn = bank[i];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (clr) bank[i] <= '0;
            else if (inen[i]) bank[i] <= busIn;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [SEL_W-1:0] s, input logic [SEL_W-1:0] d,
                                 input logic e, input logic [WIDTH-1:0] data);
        req      = r;
        src      = s;
        dst      = d;
        ext      = e;
        ext_data = data;
    endtask

    // Each accepted request expands into its per-cycle output picture.
    initial begin
        exp_t             e;
        logic [WIDTH-1:0] word;
        cur         = '0;
        checkEn     = 1'b0;
        expBusOut   = '0;
        expLastData = '0;
        forever begin
            @(posedge clk);
            if (clr) begin
                q.delete();
                cur         = '0;
                expBusOut   = '0;
                expLastData = '0;
                checkEn     = 1'b1;
            end else begin
                if (checkEn && !cur.busy && req) begin
                    word = ext ? ext_data : bank[src];
                    if (int'(dst) >= NREG || (!ext && (src == dst || int'(src) >= NREG))) begin
                        e = '0;
                        e.busy = 1'b1;
                        e.done = 1'b1;
                        e.err  = 1'b1;
                        q.push_back(e);
                    end else begin
                        e = '0;
                        e.busy  = 1'b1;
                        e.busOe = ext;
                        e.oen   = ext ? '0 : (NREG'(1) << src);
                        q.push_back(e);
                        e.inen = NREG'(1) << dst;
                        q.push_back(e);
                        e = '0;
                        e.busy  = 1'b1;
                        e.done  = 1'b1;
                        e.setLd = 1'b1;
                        e.ldVal = word;
                        e.dst   = dst;
                        q.push_back(e);
                        if (ext) expBusOut = ext_data;
                    end
                end
                if (q.size() > 0) begin
                    cur = q.pop_front();
                    if (cur.setLd) expLastData = cur.ldVal;
                end else begin
                    cur = '0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (done) doneSeen++;
            if (inen != '0) inenSeen++;
            if (checkEn) begin
                checkOutput("oen", 32'(oen), 32'(cur.oen));
                checkOutput("inen", 32'(inen), 32'(cur.inen));
                checkOutput("bus_oe", 32'(bus_oe), 32'(cur.busOe));
                checkOutput("busy", 32'(busy), 32'(cur.busy));
                checkOutput("done", 32'(done), 32'(cur.done));
                checkOutput("err", 32'(err), 32'(cur.err));
                checkOutput("bus_out", 32'(bus_out), 32'(expBusOut));
                checkOutput("last_data", 32'(last_data), 32'(expLastData));
                if (cur.setLd) checkOutput("bank_commit", 32'(bank[cur.dst]), 32'(cur.ldVal));
            end
        end
    end

    logic [NREG-1:0]  dOen, lOen, lInen;
    logic             dBusOe, fDone, fErr;
    logic [WIDTH-1:0] dBusOut, fLast, fBank;

    task automatic doXfer(input logic [SEL_W-1:0] s, input logic [SEL_W-1:0] d,
                          input logic e, input logic [WIDTH-1:0] data);
        applyStimulus(1'b1, s, d, e, data);
        @(negedge clk);
        req     = 1'b0;
        dOen    = oen;
        dBusOe  = bus_oe;
        dBusOut = bus_out;
        @(negedge clk);
        lOen  = oen;
        lInen = inen;
        @(negedge clk);
        fDone = done;
        fErr  = err;
        fLast = last_data;
        fBank = bank[d];
        @(negedge clk);
    endtask

    initial begin
        int d0;
        int i0;
        clr = 1'b1;
        applyStimulus(1'b1, 2'd1, 2'd3, 1'b0, 4'h0);
        repeat (2) @(negedge clk);
        checkOutput("reset_oen", 32'(oen), 32'h0);
        checkOutput("reset_inen", 32'(inen), 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        checkOutput("reset_done", 32'(done), 32'h0);
        checkOutput("reset_last", 32'(last_data), 32'h0);
        clr = 1'b0;
        req = 1'b0;
        @(negedge clk);
        checkOutput("reset_no_start", 32'(busy), 32'h0);

        doXfer(2'd0, 2'd1, 1'b1, 4'b0101);
        checkOutput("preload_last", 32'(fLast), 32'h5);

        doXfer(2'd1, 2'd3, 1'b0, 4'h0);
        checkOutput("r2r_drive_oen", 32'(dOen), 32'b0010);
        checkOutput("r2r_latch_oen", 32'(lOen), 32'b0010);
        checkOutput("r2r_latch_inen", 32'(lInen), 32'b1000);
        checkOutput("r2r_done", 32'(fDone), 32'h1);
        checkOutput("r2r_err", 32'(fErr), 32'h0);
        checkOutput("r2r_last", 32'(fLast), 32'b0101);
        checkOutput("r2r_reg3", 32'(fBank), 32'b0101);

        doXfer(2'd0, 2'd2, 1'b1, 4'b1101);
        checkOutput("ext_drive_oe", 32'(dBusOe), 32'h1);
        checkOutput("ext_drive_out", 32'(dBusOut), 32'b1101);
        checkOutput("ext_latch_inen", 32'(lInen), 32'b0100);
        checkOutput("ext_done", 32'(fDone), 32'h1);
        checkOutput("ext_last", 32'(fLast), 32'b1101);
        checkOutput("ext_reg2", 32'(fBank), 32'b1101);

        applyStimulus(1'b1, 2'd2, 2'd2, 1'b0, 4'h0);
        @(negedge clk);
        req = 1'b0;
        checkOutput("rej_done", 32'(done), 32'h1);
        checkOutput("rej_err", 32'(err), 32'h1);
        checkOutput("rej_enables", 32'({oen, inen}), 32'h0);
        @(negedge clk);
        checkOutput("rej_idle", 32'({busy, done, err}), 32'h0);

        d0 = doneSeen;
        applyStimulus(1'b1, 2'd0, 2'd1, 1'b0, 4'h0);
        @(negedge clk);
        applyStimulus(1'b1, 2'd2, 2'd3, 1'b0, 4'h0);
        repeat (2) @(negedge clk);
        req = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("busy_one_done", 32'(doneSeen - d0), 32'd1);

        i0 = inenSeen;
        applyStimulus(1'b1, 2'd1, 2'd0, 1'b0, 4'h0);
        @(negedge clk);
        clr = 1'b1;
        req = 1'b0;
        @(negedge clk);
        checkOutput("abort_enables", 32'({oen, inen, bus_oe}), 32'h0);
        checkOutput("abort_busy", 32'(busy), 32'h0);
        clr = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("abort_no_inen", 32'(inenSeen - i0), 32'd0);

        d0 = doneSeen;
        for (int k = 0; k < 12; k++) begin
            applyStimulus(1'b1, SEL_W'(k % 2), SEL_W'((k + 1) % 2), 1'b0, 4'h0);
            @(negedge clk);
        end
        req = 1'b0;
        @(negedge clk);
        checkOutput("b2b_dones", 32'(doneSeen - d0), 32'd3);

        for (int k = 0; k < 600; k++) begin
            clr = ($urandom_range(0, 49) == 0);
            applyStimulus($urandom_range(0, 1) == 1, SEL_W'($urandom_range(0, NREG - 1)),
                          SEL_W'($urandom_range(0, NREG - 1)), $urandom_range(0, 3) == 0,
                          WIDTH'($urandom_range(0, 15)));
            @(negedge clk);
        end
        clr = 1'b0;
        req = 1'b0;
        repeat (6) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
